// File: rtl/muxed_scan_bank_if.sv
// muxed_scan_bank_if: functional, scan and sequencer signals of the scan register bank.
`default_nettype none

interface muxed_scan_bank_if #(
  parameter int WIDTH  = 8,
  parameter int CHAINS = 1
);
  logic [WIDTH-1:0]  d;
  logic [WIDTH-1:0]  q;
  logic              fe;
  logic              se_ext;
  logic [CHAINS-1:0] si;
  logic [CHAINS-1:0] so;
  logic              start;
  logic              busy;
  logic              done;
  logic [15:0]       sig;

  modport master (
    output d, fe, se_ext, si, start,
    input  q, so, busy, done, sig
  );

  modport slave (
    input  d, fe, se_ext, si, start,
    output q, so, busy, done, sig
  );
endinterface

`default_nettype wire

// File: rtl/muxed_scan_bank.sv
// muxed_scan_bank: muxed-D scan register bank with shift/capture sequencer.
// Optional MISR signature on the scan-out bits is enabled with SCAN_MISR_EN.
`default_nettype none

module muxed_scan_bank #(
  parameter int WIDTH  = 8,
  parameter int CHAINS = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  muxed_scan_bank_if.slave bus
);
  localparam int CHAIN_LEN = WIDTH / CHAINS;
  localparam int CNT_W     = $clog2(CHAIN_LEN + 1);
  localparam logic [CNT_W-1:0] C_LAST = CNT_W'(CHAIN_LEN - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_CAPT  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t            r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic [WIDTH-1:0]  r_q;
  logic              r_busy;
  logic              r_done;
  logic [WIDTH-1:0]  w_shift;
  logic [CHAINS-1:0] w_so;

  // Each chain shifts toward its low bit; SI enters at the top.
  for (genvar c = 0; c < CHAINS; c++) begin : g_chain
    if (CHAIN_LEN == 1) begin : g_single
      assign w_shift[c] = bus.si[c];
    end else begin : g_multi
      assign w_shift[c*CHAIN_LEN +: CHAIN_LEN] =
        {bus.si[c], r_q[c*CHAIN_LEN+1 +: CHAIN_LEN-1]};
    end
    assign w_so[c] = r_q[c*CHAIN_LEN];
  end

`ifdef SCAN_MISR_EN
  logic [15:0] r_sig;
  logic [15:0] w_sig_next;
  assign w_sig_next = {r_sig[14:0], 1'b0} ^ (r_sig[15] ? 16'h1021 : 16'h0000) ^ 16'(w_so);
  assign bus.sig    = r_sig;
`else
  assign bus.sig = 16'h0000;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_q     <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
`ifdef SCAN_MISR_EN
      r_sig   <= 16'h0000;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          // An accepted start takes the edge: no shift and no load.
          if (bus.start) begin
            r_state <= S_SHIFT;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
`ifdef SCAN_MISR_EN
            r_sig   <= 16'h0000;
`endif
          end else if (bus.se_ext) begin
            r_q <= w_shift;
          end else if (bus.fe) begin
            r_q <= bus.d;
          end
        end
        S_SHIFT: begin
          r_q   <= w_shift;
          r_cnt <= r_cnt + 1'b1;
`ifdef SCAN_MISR_EN
          r_sig <= w_sig_next;
`endif
          if (r_cnt == C_LAST) begin
            r_state <= S_CAPT;
          end
        end
        S_CAPT: begin
          r_q     <= bus.d;
          r_state <= S_DONE;
          r_busy  <= 1'b0;
          r_done  <= 1'b1;
        end
        default: begin
          r_state <= S_IDLE;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.q    = r_q;
  assign bus.so   = w_so;
  assign bus.busy = r_busy;
  assign bus.done = r_done;
endmodule

`default_nettype wire
